// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS fetch-stage sequencing logic.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Pipeline control bundle driven by the fetch controller.
  typedef struct packed {
    logic imem_req;
    logic pc_we;
    logic pc_src;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
  } ctrl_t;

  // Quiescent controls: nothing fetched, every boundary flushed.
  localparam ctrl_t CTRL_HOLD = '{
    imem_req:     1'b0,
    pc_we:        1'b0,
    pc_src:       1'b0,
    if_id_we:     1'b0,
    if_id_flush:  1'b1,
    id_ex_bubble: 1'b1,
    ex_mem_flush: 1'b1
  };

endpackage

// File: rtl/if_stage_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a nonzero register read by ID.
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  output logic       hz
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (id_ex_rt == if_id_rs);
  assign rt_match = if_id_uses_rt && (id_ex_rt == if_id_rt);
  assign hz       = id_ex_mem_read && (id_ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage sequencer: issues imem requests, steers the PC and generates
// stall/flush controls for IF/ID, ID/EX and EX/MEM. Outputs are Mealy.
module if_stage_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_MEM_PCSrc,
  input  logic [31:0]      EX_MEM_NPC,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_we,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]       pending_q, pending_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic        hz;
  logic        stall_inc;
  logic        flush_inc;
  ctrl_t       ctrl;
  logic [31:0] target;

  hazard_detect u_hazard_detect (
    .id_ex_mem_read (ID_EX_MemRead),
    .id_ex_rt       (ID_EX_rt),
    .if_id_rs       (IF_ID_rs),
    .if_id_rt       (IF_ID_rt),
    .if_id_uses_rt  (IF_ID_uses_rt),
    .hz             (hz)
  );

  // Handshake: imem_req is the valid, imem_ready the ready. Once raised in
  // S_RUN/S_DRAIN the request stays high until a cycle with imem_ready=1;
  // only rst may withdraw it. The PC (and so the address) only advances on
  // a cycle where the fetch completes.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pending_d  = pending_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    ctrl       = CTRL_HOLD;
    target     = 32'h0;

    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = S_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        ctrl          = '0;
        ctrl.imem_req = 1'b1;
        target        = EX_MEM_NPC;
        if (EX_MEM_PCSrc) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          ctrl.ex_mem_flush = 1'b1;
          flush_inc         = 1'b1;
          if (imem_ready) begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = 1'b1;
          end else begin
            // Fetch still in flight: remember where to go once it lands.
            pending_d = EX_MEM_NPC;
            state_d   = S_DRAIN;
          end
        end else if (hz) begin
          ctrl.id_ex_bubble = 1'b1;
          stall_inc         = 1'b1;
        end else if (!imem_ready) begin
          ctrl.if_id_flush = 1'b1;
          stall_inc        = 1'b1;
        end else begin
          ctrl.pc_we    = 1'b1;
          ctrl.if_id_we = 1'b1;
        end
      end

      S_DRAIN: begin
        ctrl             = '0;
        ctrl.imem_req    = 1'b1;
        ctrl.if_id_flush = 1'b1;
        target           = pending_q;
        if (EX_MEM_PCSrc) begin
          pending_d         = EX_MEM_NPC;
          ctrl.id_ex_bubble = 1'b1;
          ctrl.ex_mem_flush = 1'b1;
          flush_inc         = 1'b1;
        end
        if (imem_ready) begin
          // Stale instruction is dropped; jump to the newest redirect.
          ctrl.pc_we  = 1'b1;
          ctrl.pc_src = 1'b1;
          target      = EX_MEM_PCSrc ? EX_MEM_NPC : pending_q;
          state_d     = S_RUN;
        end
      end

      default: begin
        state_d    = S_BOOT;
        boot_cnt_d = '0;
      end
    endcase

    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    if (rst) begin
      ctrl   = CTRL_HOLD;
      target = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      pending_q   <= 32'h0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_req     = ctrl.imem_req;
  assign pc_we        = ctrl.pc_we;
  assign pc_src       = ctrl.pc_src;
  assign if_id_we     = ctrl.if_id_we;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign pc_target    = target;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios then random traffic, all
// checked cycle by cycle against a behavioural model of the fetch sequencer.
module tb_if_stage_ctrl;
  import mips_pipe_pkg::*;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             EX_MEM_PCSrc;
  logic [31:0]      EX_MEM_NPC;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic             IF_ID_uses_rt;
  logic             imem_ready;
  logic             imem_req, pc_we, pc_src, if_id_we;
  logic             if_id_flush, id_ex_bubble, ex_mem_flush;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       dbg_state;

  if_stage_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_PCSrc(EX_MEM_PCSrc), .EX_MEM_NPC(EX_MEM_NPC),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc_we(pc_we), .pc_src(pc_src),
    .pc_target(pc_target), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // boot_left counts the remaining blind cycles; draining means a redirect is
  // waiting for the outstanding fetch to return.
  int          boot_left;
  bit          draining;
  logic [31:0] pend;
  int          m_stall, m_flush;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_reset();
    boot_left = BOOT_CYCLES;
    draining  = 1'b0;
    pend      = 32'h0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit r, input bit br, input logic [31:0] npc,
                             input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                             input logic [4:0] rt, input bit uses, input bit rdy);
    logic [6:0]  e_ctrl;
    logic [31:0] e_tgt;
    logic [1:0]  e_state;
    bit          hazard;
    rst = r; EX_MEM_PCSrc = br; EX_MEM_NPC = npc; ID_EX_MemRead = mr;
    ID_EX_rt = ert; IF_ID_rs = rs; IF_ID_rt = rt; IF_ID_uses_rt = uses; imem_ready = rdy;
    #2;
    hazard = mr && (ert != 0) && ((ert == rs) || (uses && ert == rt));
    e_state = (boot_left > 0) ? S_BOOT : (draining ? S_DRAIN : S_RUN);
    // {imem_req, pc_we, pc_src, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush}
    if (r || boot_left > 0) begin
      e_ctrl = 7'b0000111; e_tgt = 32'h0;
    end else if (!draining) begin
      e_tgt = npc;
      if (br && rdy)      e_ctrl = 7'b1110111;
      else if (br)        e_ctrl = 7'b1000111;
      else if (hazard)    e_ctrl = 7'b1000010;
      else if (!rdy)      e_ctrl = 7'b1000100;
      else                e_ctrl = 7'b1101000;
    end else begin
      e_ctrl = {1'b1, rdy, rdy, 1'b0, 1'b1, br, br};
      e_tgt  = (rdy && br) ? npc : pend;
    end
    check("ctrl", 32'({imem_req, pc_we, pc_src, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush}),
          32'(e_ctrl));
    check("pc_target", pc_target, e_tgt);
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    check("state", 32'(dbg_state), 32'(e_state));
    @(posedge clk);
    if (r) model_reset();
    else if (boot_left > 0) boot_left--;
    else if (!draining) begin
      if (br) begin
        m_flush = sat(m_flush + 1);
        if (!rdy) begin pend = npc; draining = 1'b1; end
      end else if (hazard || !rdy) begin
        m_stall = sat(m_stall + 1);
      end
    end else begin
      if (br) begin pend = npc; m_flush = sat(m_flush + 1); end
      if (rdy) draining = 1'b0;
    end
    #1;
  endtask

  // Shorthand for cycles without load-use traffic.
  task automatic plain(input bit r, input bit br, input logic [31:0] npc, input bit rdy);
    drive_cycle(r, br, npc, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; EX_MEM_PCSrc = 0; EX_MEM_NPC = 0; ID_EX_MemRead = 0;
    ID_EX_rt = 0; IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_uses_rt = 0; imem_ready = 0;
    @(posedge clk); #1;
    model_reset();

    // Reset held 3 cycles, then boot window, then first fetch.
    repeat (3) plain(1, 1, 32'd400, 1);
    plain(0, 1, 32'd400, 1);
    plain(0, 0, 32'd0, 1);
    plain(0, 0, 32'd0, 0);

    // Straight-line fetch.
    repeat (5) plain(0, 0, 32'h1234, 1);

    // Load-use on rs, then rt, then the $zero exemption.
    drive_cycle(0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 1'b0, 1);
    drive_cycle(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1'b1, 0);
    drive_cycle(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1'b0, 1);
    drive_cycle(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1'b1, 1);

    // Immediate redirect.
    plain(0, 1, 32'd400, 1);

    // Redirect during a memory wait, overwritten by a later redirect.
    plain(0, 1, 32'd400, 0);
    plain(0, 1, 32'd9999, 0);
    plain(0, 0, 32'd0, 0);
    plain(0, 0, 32'd0, 1);

    // Redirect + ready on the draining cycle itself.
    plain(0, 1, 32'd100, 0);
    plain(0, 1, 32'd200, 1);

    // Reset mid-drain.
    plain(0, 1, 32'h55, 0);
    plain(1, 0, 32'd0, 0);
    plain(0, 0, 32'd0, 0);
    repeat (2) plain(0, 0, 32'd0, 1);
    plain(0, 0, 32'h77, 1);

    // Saturation of both counters.
    repeat (20) plain(0, 0, 32'd0, 0);
    repeat (20) plain(0, 1, 32'($urandom), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
